// File: rtl/weight_tile_pkg.sv
// Shared types and helpers for the weight tile sequencer.
package weight_tile_pkg;

   localparam int LANES  = 16;
   localparam int ADDR_W = 17;
   localparam int DIM_W  = 12;
   localparam int CNT_W  = 5;
   localparam int IDX_W  = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } seq_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] base;
      logic [CNT_W-1:0]  rows;
      logic [LANES-1:0]  mask;
      logic              first_k;
      logic              last_k;
   } tile_desc_t;

   // Thermometer mask with the low n lanes set (n in 0..LANES).
   function automatic logic [LANES-1:0] mask_from_count(input logic [CNT_W-1:0] n);
      logic [LANES-1:0] m;
      m = {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         m[i] = (CNT_W'(i) < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/weight_tile_sequencer_dim_counter.sv
// Per-dimension tile walker: remaining elements, first/last tile flags.
module tile_dim_counter
   import weight_tile_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             step,
   input  logic [DIM_W-1:0] dim,
   output logic [CNT_W-1:0] count,
   output logic             first,
   output logic             last
);

   logic [DIM_W-1:0] remain_r;
   logic             first_r;

   // Reload the full dimension on clear, consume one tile's worth on step
   always_ff @(posedge clock) begin
      if (reset) begin
         remain_r <= {DIM_W{1'b0}};
         first_r  <= 1'b0;
      end else if (clear) begin
         remain_r <= dim;
         first_r  <= 1'b1;
      end else if (step) begin
         remain_r <= remain_r - DIM_W'(LANES);
         first_r  <= 1'b0;
      end
   end

   // Clamp the remaining element count to one tile and flag the final tile
   always_comb begin
      if (remain_r >= DIM_W'(LANES)) begin
         count = CNT_W'(LANES);
      end else begin
         count = remain_r[CNT_W-1:0];
      end
      last  = (remain_r <= DIM_W'(LANES));
      first = first_r;
   end

endmodule

// File: rtl/weight_tile_sequencer.sv
// Walks a K x N row-major weight matrix in 16x16 tiles (N outer, K inner)
// and hands one descriptor at a time to the tiling address generator.
module weight_tile_sequencer
   import weight_tile_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              io_start,
   input  logic              io_abort,
   input  logic [DIM_W-1:0]  io_cfgK,
   input  logic [DIM_W-1:0]  io_cfgN,
   input  logic [ADDR_W-1:0] io_cfgBase,
   output logic              io_busy,
   output logic              io_done,
   output logic              io_tileValid,
   input  logic              io_tileReady,
   output logic [ADDR_W-1:0] io_tileBase,
   output logic [DIM_W-1:0]  io_tileStride,
   output logic [CNT_W-1:0]  io_tileRows,
   output logic [LANES-1:0]  io_laneMask,
   output logic              io_tileFirstK,
   output logic              io_tileLastK,
   output logic [IDX_W-1:0]  io_tileIdx,
   input  logic              io_genDone
);

   seq_state_t        state_r, next_state_s;
   logic [DIM_W-1:0]  k_r, n_r;
   logic [ADDR_W-1:0] base_r, col_base_r;
   logic [IDX_W-1:0]  idx_r;
   logic              last_tile_r;
   tile_desc_t        desc_r;
   logic              valid_r, busy_r, done_r;
   logic              valid_nx_s, busy_nx_s, done_nx_s, load_desc_s;

   logic              start_acc_s, accept_s, gen_done_s, zero_dim_s;
   logic [CNT_W-1:0]  k_cnt_s, n_cnt_s;
   logic              k_first_s, k_last_s, n_first_s, n_last_s;

   assign start_acc_s = (state_r == IDLE) && io_start;
   assign accept_s    = (state_r == ISSUE) && io_tileReady && !io_abort;
   assign gen_done_s  = (state_r == WAIT) && io_genDone && !io_abort;
   assign zero_dim_s  = (k_r == {DIM_W{1'b0}}) || (n_r == {DIM_W{1'b0}});

   // K walker restarts at every new N-tile; the config is taken straight
   // from the inputs on the start cycle because the latch lands together.
   tile_dim_counter u_k_cnt (
      .clock (clock),
      .reset (reset),
      .clear (start_acc_s || (accept_s && k_last_s)),
      .step  (accept_s && !k_last_s),
      .dim   (start_acc_s ? io_cfgK : k_r),
      .count (k_cnt_s),
      .first (k_first_s),
      .last  (k_last_s)
   );

   tile_dim_counter u_n_cnt (
      .clock (clock),
      .reset (reset),
      .clear (start_acc_s),
      .step  (accept_s && k_last_s && !n_last_s),
      .dim   (io_cfgN),
      .count (n_cnt_s),
      .first (n_first_s),
      .last  (n_last_s)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; abort outranks everything outside IDLE
   always_comb begin
      next_state_s = state_r;
      if ((state_r != IDLE) && io_abort) begin
         next_state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (io_start) next_state_s = CHECK;
               else          next_state_s = IDLE;
            end
            CHECK: begin
               // Empty matrix, or walkers not parked on tile 0: nothing to issue
               if (zero_dim_s || !(k_first_s && n_first_s)) next_state_s = DONE;
               else                                         next_state_s = ISSUE;
            end
            ISSUE: begin
               if (io_tileReady) next_state_s = WAIT;
               else              next_state_s = ISSUE;
            end
            WAIT: begin
               if (io_genDone) begin
                  if (last_tile_r) next_state_s = DONE;
                  else             next_state_s = ISSUE;
               end else begin
                  next_state_s = WAIT;
               end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
         endcase
      end
   end

   // Output decode from the upcoming state so the flags can be registered
   always_comb begin
      valid_nx_s = 1'b0;
      busy_nx_s  = 1'b0;
      done_nx_s  = 1'b0;
      case (next_state_s)
         CHECK: busy_nx_s = 1'b1;
         ISSUE: begin
            valid_nx_s = 1'b1;
            busy_nx_s  = 1'b1;
         end
         WAIT:  busy_nx_s = 1'b1;
         DONE:  done_nx_s = 1'b1;
         default: begin
            valid_nx_s = 1'b0;
            busy_nx_s  = 1'b0;
            done_nx_s  = 1'b0;
         end
      endcase
      load_desc_s = (next_state_s == ISSUE) && (state_r != ISSUE);
   end

   // Registered handshake flags and descriptor, frozen while ISSUE waits
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         desc_r  <= '{base: {ADDR_W{1'b0}}, rows: {CNT_W{1'b0}}, mask: {LANES{1'b0}},
                      first_k: 1'b0, last_k: 1'b0};
      end else begin
         valid_r <= valid_nx_s;
         busy_r  <= busy_nx_s;
         done_r  <= done_nx_s;
         if (load_desc_s) begin
            desc_r <= '{base: base_r, rows: k_cnt_s, mask: mask_from_count(n_cnt_s),
                        first_k: k_first_s, last_k: k_last_s};
         end
      end
   end

   // Config latch and address walk; the next tile is prepared at accept
   // so its descriptor is ready the cycle genDone arrives.
   always_ff @(posedge clock) begin
      if (reset) begin
         k_r         <= {DIM_W{1'b0}};
         n_r         <= {DIM_W{1'b0}};
         base_r      <= {ADDR_W{1'b0}};
         col_base_r  <= {ADDR_W{1'b0}};
         idx_r       <= {IDX_W{1'b0}};
         last_tile_r <= 1'b0;
      end else if (start_acc_s) begin
         k_r         <= io_cfgK;
         n_r         <= io_cfgN;
         base_r      <= io_cfgBase;
         col_base_r  <= io_cfgBase;
         idx_r       <= {IDX_W{1'b0}};
         last_tile_r <= 1'b0;
      end else begin
         if (accept_s) begin
            last_tile_r <= k_last_s && n_last_s;
            if (k_last_s) begin
               col_base_r <= col_base_r + ADDR_W'(LANES);
               base_r     <= col_base_r + ADDR_W'(LANES);
            end else begin
               base_r     <= base_r + ADDR_W'({n_r, 4'b0000});
            end
         end
         if (gen_done_s) begin
            idx_r <= idx_r + 16'd1;
         end
      end
   end

   assign io_busy       = busy_r;
   assign io_done       = done_r;
   assign io_tileValid  = valid_r;
   assign io_tileBase   = desc_r.base;
   assign io_tileRows   = desc_r.rows;
   assign io_laneMask   = desc_r.mask;
   assign io_tileFirstK = desc_r.first_k;
   assign io_tileLastK  = desc_r.last_k;
   assign io_tileStride = n_r;
   assign io_tileIdx    = idx_r;

endmodule

// File: tb/tb_weight_tile_sequencer.sv
// Scoreboard bench for weight_tile_sequencer: a plain-arithmetic tile list
// model feeds an expectation queue that a monitor drains on each handshake.
module tb_weight_tile_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        io_start = 1'b0;
   logic        io_abort = 1'b0;
   logic [11:0] io_cfgK = 12'd0;
   logic [11:0] io_cfgN = 12'd0;
   logic [16:0] io_cfgBase = 17'd0;
   logic        io_busy, io_done, io_tileValid;
   logic        io_tileReady = 1'b0;
   logic [16:0] io_tileBase;
   logic [11:0] io_tileStride;
   logic [4:0]  io_tileRows;
   logic [15:0] io_laneMask;
   logic        io_tileFirstK, io_tileLastK;
   logic [15:0] io_tileIdx;
   logic        io_genDone;
   logic        gd_resp = 1'b0;
   logic        gd_noise = 1'b0;

   assign io_genDone = gd_resp | gd_noise;

   always #5 clock = ~clock;

   weight_tile_sequencer dut (
      .clock(clock), .reset(reset), .io_start(io_start), .io_abort(io_abort),
      .io_cfgK(io_cfgK), .io_cfgN(io_cfgN), .io_cfgBase(io_cfgBase),
      .io_busy(io_busy), .io_done(io_done), .io_tileValid(io_tileValid),
      .io_tileReady(io_tileReady), .io_tileBase(io_tileBase),
      .io_tileStride(io_tileStride), .io_tileRows(io_tileRows),
      .io_laneMask(io_laneMask), .io_tileFirstK(io_tileFirstK),
      .io_tileLastK(io_tileLastK), .io_tileIdx(io_tileIdx),
      .io_genDone(io_genDone)
   );

   typedef struct {
      int base; int rows; int mask; int first_k; int last_k; int idx; int stride;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   int          done_pending = 0;
   int          ready_mode = 0;
   int          resp_delay = 3;
   int          hold_cnt = 0;
   logic        prev_hold = 1'b0;
   logic [55:0] prev_desc = 56'd0;
   logic [55:0] desc_now;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Expected tile list for one layer, straight from the tiling rules
   function automatic void model_push(input int k, input int n, input int base);
      int   kt_n, nt_n, idx, cols;
      exp_t e;
      kt_n = (k + 15) / 16;
      nt_n = (n + 15) / 16;
      idx  = 0;
      for (int nt = 0; nt < nt_n; nt++) begin
         for (int kt = 0; kt < kt_n; kt++) begin
            e.base    = (base + nt * 16 + kt * 16 * n) & 'h1FFFF;
            e.rows    = (k - 16 * kt > 16) ? 16 : k - 16 * kt;
            cols      = (n - 16 * nt > 16) ? 16 : n - 16 * nt;
            e.mask    = ((1 << cols) - 1) & 'hFFFF;
            e.first_k = (kt == 0) ? 1 : 0;
            e.last_k  = (kt == kt_n - 1) ? 1 : 0;
            e.idx     = idx;
            e.stride  = n;
            idx++;
            exp_q.push_back(e);
         end
      end
   endfunction

   // Ready driver plus spurious genDone pulses while a descriptor is held
   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (ready_mode)
            0: io_tileReady = 1'b1;
            1: io_tileReady = ($urandom_range(0, 1) == 1);
            default: begin
               if (io_tileValid) begin
                  io_tileReady = (hold_cnt >= 7);
                  hold_cnt++;
               end else begin
                  hold_cnt = 0;
                  io_tileReady = 1'b0;
               end
            end
         endcase
         gd_noise = (ready_mode == 2) && io_tileValid && !io_tileReady &&
                    ($urandom_range(0, 1) == 1);
      end
   end

   // Generator model: one genDone pulse some cycles after each accept
   initial begin
      int d;
      forever begin
         @(negedge clock);
         if (io_tileValid && io_tileReady && !reset) begin
            d = (resp_delay > 0) ? resp_delay : int'($urandom_range(1, 4));
            repeat (d) @(posedge clock);
            #1 gd_resp = 1'b1;
            @(posedge clock);
            #1 gd_resp = 1'b0;
         end
      end
   end

   // Monitor: hold stability, descriptor scoreboard, done accounting
   initial begin
      forever begin
         @(negedge clock);
         desc_now = {io_tileBase, io_tileRows, io_laneMask, io_tileFirstK, io_tileLastK, io_tileIdx};
         if (prev_hold) begin
            chk("hold_valid", io_tileValid, 1);
            chk("hold_desc", desc_now, prev_desc);
         end
         prev_hold = io_tileValid && !io_tileReady && !reset;
         prev_desc = desc_now;
         if (io_tileValid && io_tileReady) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_tile: got base 0x%0h required no tile", io_tileBase);
            end else begin
               mon_e = exp_q.pop_front();
               chk("tile_base", io_tileBase, mon_e.base);
               chk("tile_rows", io_tileRows, mon_e.rows);
               chk("tile_mask", io_laneMask, mon_e.mask);
               chk("tile_firstk", io_tileFirstK, mon_e.first_k);
               chk("tile_lastk", io_tileLastK, mon_e.last_k);
               chk("tile_idx", io_tileIdx, mon_e.idx);
               chk("tile_stride", io_tileStride, mon_e.stride);
            end
         end
         if (io_done) begin
            chk("done_expected", done_pending > 0, 1);
            chk("done_all_tiles", exp_q.size(), 0);
            chk("done_busy", io_busy, 0);
            if (done_pending > 0) done_pending--;
         end
      end
   end

   task automatic run_layer(input int k, input int n, input int base, input bit meddle);
      int cyc;
      @(posedge clock);
      #1;
      io_cfgK = 12'(k);
      io_cfgN = 12'(n);
      io_cfgBase = 17'(base);
      io_start = 1'b1;
      model_push(k, n, base);
      done_pending++;
      @(posedge clock);
      #1;
      io_start = 1'b0;
      io_cfgK = 12'($urandom_range(0, 4095));
      io_cfgN = 12'($urandom_range(0, 4095));
      io_cfgBase = 17'($urandom_range(0, 131071));
      @(negedge clock);
      chk("lat_busy_t1", io_busy, 1);
      chk("lat_valid_t1", io_tileValid, 0);
      @(negedge clock);
      if (k != 0 && n != 0) begin
         chk("lat_valid_t2", io_tileValid, 1);
      end else begin
         chk("zero_done_t2", io_done, 1);
         chk("zero_busy_t2", io_busy, 0);
      end
      cyc = 0;
      while (!io_done && cyc < 20000) begin
         @(negedge clock);
         cyc++;
         if (meddle && cyc == 20) begin
            io_start = 1'b1;
            io_cfgK = 12'd16;
            io_cfgN = 12'd16;
            io_cfgBase = 17'd5;
         end
         if (meddle && cyc == 21) io_start = 1'b0;
      end
      chk("layer_timeout", cyc < 20000, 1);
      chk("queue_drained", exp_q.size(), 0);
      @(negedge clock);
      chk("post_done_busy", io_busy, 0);
      chk("post_done_pulse", io_done, 0);
   endtask

   task automatic abort_layer();
      int cyc;
      @(posedge clock);
      #1;
      io_cfgK = 12'd147;
      io_cfgN = 12'd64;
      io_cfgBase = 17'd0;
      io_start = 1'b1;
      model_push(147, 64, 0);
      done_pending++;
      @(posedge clock);
      #1;
      io_start = 1'b0;
      cyc = 0;
      while (!(io_tileIdx == 16'd5 && io_busy && !io_tileValid) && cyc < 5000) begin
         @(negedge clock);
         cyc++;
      end
      chk("abort_reach_wait", cyc < 5000, 1);
      io_abort = 1'b1;
      exp_q.delete();
      done_pending = 0;
      @(posedge clock);
      #1 io_abort = 1'b0;
      @(negedge clock);
      chk("abort_busy", io_busy, 0);
      chk("abort_valid", io_tileValid, 0);
      chk("abort_done", io_done, 0);
      repeat (10) @(negedge clock);
      chk("abort_idle_busy", io_busy, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", io_busy, 0);
      chk("rst_done", io_done, 0);
      chk("rst_valid", io_tileValid, 0);
      chk("rst_base", io_tileBase, 0);
      chk("rst_rows", io_tileRows, 0);
      chk("rst_mask", io_laneMask, 0);
      chk("rst_idx", io_tileIdx, 0);
      chk("rst_flags", {io_tileFirstK, io_tileLastK}, 0);
      chk("rst_stride", io_tileStride, 0);
      @(posedge clock);
      #1 reset = 1'b0;

      ready_mode = 0;
      resp_delay = 3;
      run_layer(147, 64, 0, 1'b0);
      run_layer(32, 20, 0, 1'b0);
      run_layer(0, 64, 100, 1'b0);
      run_layer(5, 0, 200, 1'b0);

      ready_mode = 2;
      resp_delay = 0;
      run_layer(20, 40, 'h1FFF0, 1'b0);

      ready_mode = 0;
      resp_delay = 3;
      abort_layer();
      run_layer(16, 16, 777, 1'b0);

      run_layer(147, 64, 123, 1'b1);

      ready_mode = 1;
      resp_delay = 0;
      for (int i = 0; i < 6; i++) begin
         run_layer(int'($urandom_range(1, 70)), int'($urandom_range(1, 70)),
                   int'($urandom_range(0, 131071)), 1'b0);
      end

      repeat (5) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
